// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared CSR ids, mcause encodings, CSR op codes and cause helpers
package trap_ctrl_pkg;

   // Machine-mode CSR addresses handled by trap_ctrl
   typedef enum logic [11:0] {
      CSR_MSTATUS       = 12'h300,
      CSR_MISA          = 12'h301,
      CSR_MIE           = 12'h304,
      CSR_MTVEC         = 12'h305,
      CSR_MCOUNTINHIBIT = 12'h320,
      CSR_MSCRATCH      = 12'h340,
      CSR_MEPC          = 12'h341,
      CSR_MCAUSE        = 12'h342,
      CSR_MTVAL         = 12'h343,
      CSR_MIP           = 12'h344,
      CSR_MCYCLE        = 12'hB00,
      CSR_MINSTRET      = 12'hB02,
      CSR_MCYCLEH       = 12'hB80,
      CSR_MINSTRETH     = 12'hB82,
      CSR_MVENDORID     = 12'hF11,
      CSR_MARCHID       = 12'hF12,
      CSR_MIMPID        = 12'hF13,
      CSR_MHARTID       = 12'hF14
   } csr_t;

   // Compact mcause: {interrupt, code[3:0]}
   typedef enum logic [4:0] {
      CAUSE_IADDR_MISALIGN = 5'h00,
      CAUSE_IACCESS_FAULT  = 5'h01,
      CAUSE_ILLEGAL_INSTR  = 5'h02,
      CAUSE_BREAKPOINT     = 5'h03,
      CAUSE_LADDR_MISALIGN = 5'h04,
      CAUSE_LACCESS_FAULT  = 5'h05,
      CAUSE_SADDR_MISALIGN = 5'h06,
      CAUSE_SACCESS_FAULT  = 5'h07,
      CAUSE_ECALL_M        = 5'h0B,
      CAUSE_MSI            = 5'h13,
      CAUSE_MTI            = 5'h17,
      CAUSE_MEI            = 5'h1B
   } mcause_t;

   typedef enum logic [1:0] {
      CSR_OP_RO = 2'b00,
      CSR_OP_RW = 2'b01,
      CSR_OP_RS = 2'b10,
      CSR_OP_RC = 2'b11
   } csr_op_t;

   localparam int N_CAUSES = 12;

   localparam mcause_t CAUSE_LIST [N_CAUSES] = '{
      CAUSE_IADDR_MISALIGN, CAUSE_IACCESS_FAULT, CAUSE_ILLEGAL_INSTR, CAUSE_BREAKPOINT,
      CAUSE_LADDR_MISALIGN, CAUSE_LACCESS_FAULT, CAUSE_SADDR_MISALIGN, CAUSE_SACCESS_FAULT,
      CAUSE_ECALL_M, CAUSE_MSI, CAUSE_MTI, CAUSE_MEI
   };

   function automatic logic cause_known(input logic [4:0] c);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_CAUSES; i++)
         if (c == CAUSE_LIST[i]) hit = 1'b1;
      return hit;
   endfunction

   // Expand the compact cause into the architectural 32-bit mcause layout
   function automatic logic [31:0] cause_word(input mcause_t c);
      return {c[4], 27'b0, c[3:0]};
   endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// irq_prio: fixed-priority machine interrupt selector (MEI > MSI > MTI)
// in : mie (global enable), meip/msip/mtip pending lines, meie/msie/mtie enables
// out: irq_valid (some enabled interrupt pending), irq_cause (highest-priority cause)
module irq_prio
   import trap_ctrl_pkg::*;
(
   input  logic    mie,
   input  logic    meip,
   input  logic    msip,
   input  logic    mtip,
   input  logic    meie,
   input  logic    msie,
   input  logic    mtie,
   output logic    irq_valid,
   output mcause_t irq_cause
);

   logic me, ms, mt;

   always_comb begin
      me        = meip && meie;
      ms        = msip && msie;
      mt        = mtip && mtie;
      irq_valid = mie && (me || ms || mt);
      irq_cause = me ? CAUSE_MEI : ms ? CAUSE_MSI : CAUSE_MTI;
   end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode CSR file, trap/mret sequencer and PC redirect
// in : clk, rst_n (async, active low)
//      csr_valid/csr_id/csr_op/csr_wdata   CSR instruction request
//      exc_valid/exc_cause/exc_pc/exc_tval synchronous exception
//      mret_valid, irq_pc, instr_retire, mtip/msip/meip
// out: csr_ready/csr_rdata (pre-update value), stall, redirect_valid/redirect_pc
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_valid,
   output logic        csr_ready,
   input  csr_t        csr_id,
   input  csr_op_t     csr_op,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic        exc_valid,
   input  mcause_t     exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   input  logic        mret_valid,
   input  logic [31:0] irq_pc,
   input  logic        instr_retire,
   input  logic        mtip,
   input  logic        msip,
   input  logic        meip,
   output logic        stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {S_IDLE, S_TRAP, S_MRET, S_REDIRECT} state_t;

   state_t      state_q, state_d;
   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic        meie_q, meie_d, msie_q, msie_d, mtie_q, mtie_d;
   logic        cy_inh_q, cy_inh_d, ir_inh_q, ir_inh_d;
   logic [29:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mtval_q, mtval_d;
   mcause_t     mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic [31:0] rpc_q, rpc_d;

   logic        irq_valid;
   mcause_t     irq_cause;
   logic        csr_acc, csr_wr;
   logic [31:0] old_val, new_val;

   irq_prio u_irq_prio (
      .mie       (mie_q),
      .meip      (meip),
      .msip      (msip),
      .mtip      (mtip),
      .meie      (meie_q),
      .msie      (msie_q),
      .mtie      (mtie_q),
      .irq_valid (irq_valid),
      .irq_cause (irq_cause)
   );

   // CSR access only wins when no trap-class event is present this cycle
   always_comb begin
      csr_acc = rst_n && state_q == S_IDLE && csr_valid && !exc_valid && !mret_valid && !irq_valid;
      case (csr_id)
         CSR_MSTATUS:       old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         CSR_MISA:          old_val = 32'h4000_0100;
         CSR_MIE:           old_val = {20'b0, meie_q, 3'b0, mtie_q, 3'b0, msie_q, 3'b0};
         CSR_MIP:           old_val = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
         CSR_MTVEC:         old_val = {mtvec_q, 2'b00};
         CSR_MCOUNTINHIBIT: old_val = {29'b0, ir_inh_q, 1'b0, cy_inh_q};
         CSR_MSCRATCH:      old_val = mscratch_q;
         CSR_MEPC:          old_val = mepc_q;
         CSR_MCAUSE:        old_val = cause_word(mcause_q);
         CSR_MTVAL:         old_val = mtval_q;
         CSR_MCYCLE:        old_val = mcycle_q[31:0];
         CSR_MCYCLEH:       old_val = mcycle_q[63:32];
         CSR_MINSTRET:      old_val = minstret_q[31:0];
         CSR_MINSTRETH:     old_val = minstret_q[63:32];
         default:           old_val = 32'h0;
      endcase
      new_val = csr_op == CSR_OP_RW ? csr_wdata :
                csr_op == CSR_OP_RS ? (old_val | csr_wdata) : (old_val & ~csr_wdata);
      // RS/RC with a zero operand is a pure read
      csr_wr  = csr_acc && csr_op != CSR_OP_RO && (csr_op == CSR_OP_RW || csr_wdata != 32'h0);
      csr_ready      = csr_acc;
      csr_rdata      = csr_acc ? old_val : 32'h0;
      stall          = state_q != S_IDLE;
      redirect_valid = state_q == S_REDIRECT;
      redirect_pc    = rpc_q;
   end

   always_comb begin
      state_d    = state_q;
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      meie_d     = meie_q;
      msie_d     = msie_q;
      mtie_d     = mtie_q;
      cy_inh_d   = cy_inh_q;
      ir_inh_d   = ir_inh_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mtval_d    = mtval_q;
      mcause_d   = mcause_q;
      rpc_d      = rpc_q;
      // Counters use the inhibit bits as they stood before this cycle's write
      mcycle_d   = cy_inh_q ? mcycle_q : mcycle_q + 64'd1;
      minstret_d = (instr_retire && !ir_inh_q) ? minstret_q + 64'd1 : minstret_q;
      case (state_q)
         S_IDLE: begin
            if (exc_valid) begin
               mepc_d   = {exc_pc[31:2], 2'b00};
               mcause_d = exc_cause;
               mtval_d  = exc_tval;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               state_d  = S_TRAP;
            end else if (mret_valid) begin
               mie_d   = mpie_q;
               mpie_d  = 1'b1;
               state_d = S_MRET;
            end else if (irq_valid) begin
               mepc_d   = {irq_pc[31:2], 2'b00};
               mcause_d = irq_cause;
               mtval_d  = 32'h0;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               state_d  = S_TRAP;
            end else if (csr_wr) begin
               case (csr_id)
                  CSR_MSTATUS: begin
                     mie_d  = new_val[3];
                     mpie_d = new_val[7];
                  end
                  CSR_MIE: begin
                     meie_d = new_val[11];
                     mtie_d = new_val[7];
                     msie_d = new_val[3];
                  end
                  CSR_MTVEC:         mtvec_d    = new_val[31:2];
                  CSR_MCOUNTINHIBIT: begin
                     cy_inh_d = new_val[0];
                     ir_inh_d = new_val[2];
                  end
                  CSR_MSCRATCH:      mscratch_d = new_val;
                  CSR_MEPC:          mepc_d     = {new_val[31:2], 2'b00};
                  CSR_MCAUSE:
                     if (new_val[30:4] == 27'h0 && cause_known({new_val[31], new_val[3:0]}))
                        mcause_d = mcause_t'({new_val[31], new_val[3:0]});
                  CSR_MTVAL:         mtval_d    = new_val;
                  // Writing one half suppresses the carry into the high half
                  CSR_MCYCLE:        mcycle_d   = {mcycle_q[63:32], new_val};
                  CSR_MCYCLEH:       mcycle_d[63:32] = new_val;
                  CSR_MINSTRET:      minstret_d = {minstret_q[63:32], new_val};
                  CSR_MINSTRETH:     minstret_d[63:32] = new_val;
                  default: ;
               endcase
            end
         end
         S_TRAP: begin
            rpc_d   = {mtvec_q, 2'b00};
            state_d = S_REDIRECT;
         end
         S_MRET: begin
            rpc_d   = mepc_q;
            state_d = S_REDIRECT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         meie_q     <= 1'b0;
         msie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         cy_inh_q   <= 1'b0;
         ir_inh_q   <= 1'b0;
         mtvec_q    <= RESET_MTVEC[31:2];
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mtval_q    <= 32'h0;
         mcause_q   <= CAUSE_IADDR_MISALIGN;
         mcycle_q   <= 64'h0;
         minstret_q <= 64'h0;
         rpc_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         meie_q     <= meie_d;
         msie_q     <= msie_d;
         mtie_q     <= mtie_d;
         cy_inh_q   <= cy_inh_d;
         ir_inh_q   <= ir_inh_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mtval_q    <= mtval_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
         rpc_q      <= rpc_d;
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
   import trap_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        csr_valid, csr_ready;
   csr_t        csr_id;
   csr_op_t     csr_op;
   logic [31:0] csr_wdata, csr_rdata;
   logic        exc_valid;
   mcause_t     exc_cause;
   logic [31:0] exc_pc, exc_tval;
   logic        mret_valid;
   logic [31:0] irq_pc;
   logic        instr_retire, mtip, msip, meip;
   logic        stall, redirect_valid;
   logic [31:0] redirect_pc;

   int n_cmp = 0;
   int n_bad = 0;

   trap_ctrl #(.RESET_MTVEC(32'h0000_0100)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .csr_valid      (csr_valid),
      .csr_ready      (csr_ready),
      .csr_id         (csr_id),
      .csr_op         (csr_op),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret_valid     (mret_valid),
      .irq_pc         (irq_pc),
      .instr_retire   (instr_retire),
      .mtip           (mtip),
      .msip           (msip),
      .meip           (meip),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle CSR access; checks ready and the pre-update read value
   task automatic csr_do(input string tag, input csr_t id, input csr_op_t op,
                         input logic [31:0] wd, input logic [31:0] exp);
      csr_valid = 1'b1;
      csr_id    = id;
      csr_op    = op;
      csr_wdata = wd;
      #1;
      check({tag, ".rdy"}, csr_ready, 1'b1);
      check(tag, csr_rdata, exp);
      step();
      csr_valid = 1'b0;
      csr_op    = CSR_OP_RO;
      csr_wdata = 32'h0;
   endtask

   // Walks TRAP/MRET then REDIRECT after the accepting edge
   task automatic redirect_seq(input string tag, input logic [31:0] pc);
      check({tag, ".stall1"}, stall, 1'b1);
      check({tag, ".rv1"}, redirect_valid, 1'b0);
      step();
      check({tag, ".rv2"}, redirect_valid, 1'b1);
      check({tag, ".stall2"}, stall, 1'b1);
      check({tag, ".pc"}, redirect_pc, pc);
      step();
      check({tag, ".rv3"}, redirect_valid, 1'b0);
      check({tag, ".stall3"}, stall, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      csr_valid = 1'b0; csr_id = CSR_MSTATUS; csr_op = CSR_OP_RO; csr_wdata = 32'h0;
      exc_valid = 1'b0; exc_cause = CAUSE_IADDR_MISALIGN; exc_pc = 32'h0; exc_tval = 32'h0;
      mret_valid = 1'b0; irq_pc = 32'h0; instr_retire = 1'b0;
      mtip = 1'b0; msip = 1'b0; meip = 1'b0;
      step();
      step();
      check("rst.stall", stall, 1'b0);
      check("rst.rv", redirect_valid, 1'b0);
      check("rst.rpc", redirect_pc, 32'h0);
      check("rst.rdy", csr_ready, 1'b0);
      check("rst.rdata", csr_rdata, 32'h0);
      rst_n = 1'b1;
      step();
      csr_do("rst.mtvec", CSR_MTVEC, CSR_OP_RO, 32'h0, 32'h0000_0100);
      csr_do("rst.mstatus", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1800);
      csr_do("misa", CSR_MISA, CSR_OP_RO, 32'h0, 32'h4000_0100);
      csr_do("rst.mcause", CSR_MCAUSE, CSR_OP_RO, 32'h0, 32'h0);

      // Exception with mie=0
      exc_valid = 1'b1; exc_cause = CAUSE_ILLEGAL_INSTR; exc_pc = 32'h0000_0042; exc_tval = 32'hDEAD_BEEF;
      #1;
      check("exc.stall0", stall, 1'b0);
      step();
      exc_valid = 1'b0;
      redirect_seq("exc", 32'h0000_0100);
      csr_do("exc.mepc", CSR_MEPC, CSR_OP_RO, 32'h0, 32'h0000_0040);
      csr_do("exc.mtval", CSR_MTVAL, CSR_OP_RO, 32'h0, 32'hDEAD_BEEF);
      csr_do("exc.mcause", CSR_MCAUSE, CSR_OP_RO, 32'h0, 32'h0000_0002);
      csr_do("exc.mstatus", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1800);

      // mstatus set/clear and mcause legality
      csr_do("rs.mstatus", CSR_MSTATUS, CSR_OP_RS, 32'h8, 32'h0000_1800);
      csr_do("rc0.mstatus", CSR_MSTATUS, CSR_OP_RC, 32'h0, 32'h0000_1808);
      csr_do("rc0.after", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1808);
      csr_do("mcause.bad", CSR_MCAUSE, CSR_OP_RW, 32'h8000_000F, 32'h0000_0002);
      csr_do("mcause.keep", CSR_MCAUSE, CSR_OP_RW, 32'h0000_0010, 32'h0000_0002);
      csr_do("mcause.keep2", CSR_MCAUSE, CSR_OP_RO, 32'h0, 32'h0000_0002);
      csr_do("mepc.wr", CSR_MEPC, CSR_OP_RW, 32'h0000_1237, 32'h0000_0040);
      csr_do("mepc.rd", CSR_MEPC, CSR_OP_RO, 32'h0, 32'h0000_1234);
      csr_do("unk.wr", csr_t'(12'h7C0), CSR_OP_RW, 32'hFFFF_FFFF, 32'h0);
      csr_do("mhartid", CSR_MHARTID, CSR_OP_RW, 32'h5, 32'h0);

      // Interrupt: MEI wins over MTI
      csr_do("mie.wr", CSR_MIE, CSR_OP_RW, 32'hFFFF_F7FF, 32'h0);
      csr_do("mie.rd", CSR_MIE, CSR_OP_RW, 32'h0000_0880, 32'h0000_0088);
      meip = 1'b1; mtip = 1'b1; irq_pc = 32'h0000_0200;
      csr_valid = 1'b1; csr_id = CSR_MSCRATCH; csr_op = CSR_OP_RW; csr_wdata = 32'h77;
      #1;
      check("irq.rdy", csr_ready, 1'b0);
      step();
      csr_valid = 1'b0; meip = 1'b0; mtip = 1'b0;
      redirect_seq("irq", 32'h0000_0100);
      csr_do("irq.mcause", CSR_MCAUSE, CSR_OP_RO, 32'h0, 32'h8000_000B);
      csr_do("irq.mepc", CSR_MEPC, CSR_OP_RO, 32'h0, 32'h0000_0200);
      csr_do("irq.mtval", CSR_MTVAL, CSR_OP_RO, 32'h0, 32'h0);
      csr_do("irq.mstatus", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1880);
      csr_do("irq.mscratch", CSR_MSCRATCH, CSR_OP_RO, 32'h0, 32'h0);

      // mret back to mepc
      mret_valid = 1'b1;
      step();
      mret_valid = 1'b0;
      redirect_seq("mret", 32'h0000_0200);
      csr_do("mret.mstatus", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1888);

      // Exception beats mret and CSR in the same cycle; events during trap dropped
      exc_valid = 1'b1; exc_cause = CAUSE_ECALL_M; exc_pc = 32'h0000_0300; exc_tval = 32'h0;
      mret_valid = 1'b1;
      csr_valid = 1'b1; csr_id = CSR_MSCRATCH; csr_op = CSR_OP_RW; csr_wdata = 32'h1234;
      #1;
      check("pri.rdy", csr_ready, 1'b0);
      check("pri.rdata", csr_rdata, 32'h0);
      step();
      exc_valid = 1'b0; mret_valid = 1'b0;
      #1;
      check("trap.rdy", csr_ready, 1'b0);
      redirect_seq("pri", 32'h0000_0100);
      csr_valid = 1'b0;
      csr_do("pri.mcause", CSR_MCAUSE, CSR_OP_RO, 32'h0, 32'h0000_000B);
      csr_do("pri.mepc", CSR_MEPC, CSR_OP_RO, 32'h0, 32'h0000_0300);
      csr_do("pri.mscratch", CSR_MSCRATCH, CSR_OP_RO, 32'h0, 32'h0);
      csr_do("pri.mstatus", CSR_MSTATUS, CSR_OP_RO, 32'h0, 32'h0000_1880);

      // mcycle carry, same-cycle half write, inhibit timing
      csr_do("cy.wlo", CSR_MCYCLE, CSR_OP_RW, 32'hFFFF_FFFF, dut.mcycle_q[31:0]);
      csr_do("cy.lo0", CSR_MCYCLE, CSR_OP_RO, 32'h0, 32'hFFFF_FFFF);
      csr_do("cy.hi1", CSR_MCYCLEH, CSR_OP_RO, 32'h0, 32'h1);
      csr_do("cy.lo1", CSR_MCYCLE, CSR_OP_RO, 32'h0, 32'h1);
      csr_do("cy.whi", CSR_MCYCLEH, CSR_OP_RW, 32'h5, 32'h1);
      csr_do("cy.lo3", CSR_MCYCLE, CSR_OP_RO, 32'h0, 32'h3);
      csr_do("cy.hi5", CSR_MCYCLEH, CSR_OP_RO, 32'h0, 32'h5);
      csr_do("inh.wr", CSR_MCOUNTINHIBIT, CSR_OP_RW, 32'h1, 32'h0);
      csr_do("inh.lo6", CSR_MCYCLE, CSR_OP_RO, 32'h0, 32'h6);
      csr_do("inh.lo6b", CSR_MCYCLE, CSR_OP_RO, 32'h0, 32'h6);
      csr_do("inh.rd", CSR_MCOUNTINHIBIT, CSR_OP_RO, 32'h0, 32'h1);

      instr_retire = 1'b1;
      step(); step(); step();
      instr_retire = 1'b0;
      csr_do("minstret", CSR_MINSTRET, CSR_OP_RO, 32'h0, 32'h3);

      // Reset in the middle of a trap
      exc_valid = 1'b1; exc_cause = CAUSE_BREAKPOINT; exc_pc = 32'h0000_0500;
      step();
      exc_valid = 1'b0;
      check("mid.stall", stall, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid.rst.stall", stall, 1'b0);
      check("mid.rst.rv", redirect_valid, 1'b0);
      check("mid.rst.rpc", redirect_pc, 32'h0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("mid.norv", redirect_valid, 1'b0);
         check("mid.nostall", stall, 1'b0);
         step();
      end
      csr_do("mid.mepc", CSR_MEPC, CSR_OP_RO, 32'h0, 32'h0);
      csr_do("mid.inh", CSR_MCOUNTINHIBIT, CSR_OP_RO, 32'h0, 32'h0);
      csr_do("mid.mtvec", CSR_MTVEC, CSR_OP_RO, 32'h0, 32'h0000_0100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Owns the machine-mode CSR state and sequences every change to it: CSR instruction accesses, synchronous exception entry, interrupt entry, mret return, and mcycle/minstret counting. Sits beside the execute stage. Arbitrates between core requests and trap events, stalls the pipeline while a trap or mret is in flight, and issues the PC redirect to fetch.

Parameters:
RESET_MTVEC, 32'h0000_0000, mtvec value after reset (bits [1:0] ignored, mode fixed direct)

Ports:
clk  in  1  core clock; one clock domain, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
csr_valid  in  1  CSR instruction request
csr_ready  out  1  request accepted this cycle
csr_id  in  csr_t  target CSR
csr_op  in  2  01 RW, 10 RS, 11 RC, 00 read-only
csr_wdata  in  32  write/set/clear operand
csr_rdata  out  32  pre-update CSR value; valid when csr_ready=1
exc_valid  in  1  synchronous exception reported
exc_cause  in  mcause_t  exception cause
exc_pc  in  32  faulting PC
exc_tval  in  32  trap value
mret_valid  in  1  mret executing
irq_pc  in  32  PC of next unexecuted instruction (interrupt mepc)
instr_retire  in  1  one instruction retired this cycle
mtip, msip, meip  in  1 each  interrupt pending lines (level)
stall  out  1  freeze pipeline
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  32  jump target

Behaviour:
- Reset (async, rst_n=0): FSM IDLE; mie, mpie, mtie, msie, meie, mcycle, minstret, both inhibits, mscratch, mepc, mtval all 0; mcause all-zero encoding; mtvec_base=RESET_MTVEC[31:2]. Outputs: stall=0, redirect_valid=0, redirect_pc=0, csr_ready=0, csr_rdata=0.
- FSM states: IDLE, TRAP, MRET, REDIRECT.
- IDLE event priority, highest first: exc_valid > mret_valid > interrupt > csr_valid. At most one event is accepted per cycle.
- Interrupt condition: mie && ((meip&&meie) || (msip&&msie) || (mtip&&mtie)). Cause priority: MEI > MSI > MTI.
- Exception in IDLE: at the clock edge, mepc<=exc_pc with [1:0] cleared, mcause<=exc_cause, mtval<=exc_tval, mpie<=mie, mie<=0; go to TRAP. This applies even when mie=0.
- Interrupt in IDLE: same update with mepc<=irq_pc, mcause=selected interrupt cause, mtval<=0; go to TRAP.
- mret in IDLE: mie<=mpie, mpie<=1; go to MRET.
- TRAP: stall=1; latch redirect_pc={mtvec_base,2'b00}; go to REDIRECT.
- MRET: stall=1; latch redirect_pc=mepc; go to REDIRECT.
- REDIRECT: redirect_valid=1, stall=1 for exactly one cycle; then IDLE.
- Latency: event accepted at edge N, redirect_valid high in cycle N+2.
- Events in TRAP/MRET/REDIRECT are dropped and csr_ready=0. Interrupt lines are level signals and are re-sampled in IDLE.
- CSR access: csr_ready=1 combinationally only in IDLE with no higher-priority event. csr_rdata=current value.
- CSR new value: RW=wdata; RS=old|wdata; RC=old&~wdata; op 00 or (RS/RC with wdata==0) writes nothing.
- CSR write rules:
  - mstatus: bits 7 and 3 only.
  - mie: bits 11, 7, 3.
  - mtvec: [31:2].
  - mepc: [1:0] forced 0.
  - mcountinhibit: bits 0 and 2.
  - mcause: written only if {wd[31],wd[3:0]} is a recognized cause and wd[30:4]==0; otherwise retained.
  - Read-only/ID CSRs: write ignored.
  - Unknown csr_id: reads 0, write ignored.
- Read layout: mstatus MPP reads 2'b11; misa reads RV32I; vendor/arch/impl/hart IDs read 0.
- Counters: mcycle+=1 every cycle unless mcycle_inhibit; minstret+=1 on instr_retire unless minstret_inhibit. Both are 64-bit with carry from the low word into the high word; 2^64-1 wraps to 0.
- CSR write to a counter half in the same cycle: written half takes wdata exactly (no +1); other half holds with no carry. Inhibit written this cycle takes effect next cycle.
- Reset asserted mid-TRAP/MRET: immediate IDLE, no redirect pulse, all state reset.

Decomposition:
- Package enums (shared): csr_t, mcause_t, csr_op_t encodings, and the recognized-cause list as a constant array.
- FSM state enum stays local to the module.
- One sub-module: irq_prio (combinational pending&enable&mie -> valid + mcause_t, fixed MEI>MSI>MTI).

Test Plan:
- Reset with RESET_MTVEC=32'h0000_0100, then exc_valid, cause ILLEGAL_INSTR, exc_pc=32'h0000_0042, tval=32'hDEAD_BEEF -> 2 cycles later redirect_valid=1, redirect_pc=32'h100; mepc=32'h40; mtval=32'hDEADBEEF; mie=0; mpie=old mie.
- mie=1; meie=mtie=1; meip=mtip=1; irq_pc=32'h200 -> mcause=MEI, mepc=32'h200, mtval=0; subsequent mret -> redirect_pc=32'h200, mie=1, mpie=1.
- exc_valid, mret_valid and csr_valid asserted together in IDLE -> only the exception is taken; csr_ready=0; mret ignored.
- CSR RS mstatus wdata=32'h8 -> rdata shows old value with mie=0, mie becomes 1; RC with wdata=0 -> no change; mcause RW 32'h8000_000F -> mcause unchanged.
- mcycle=32'hFFFF_FFFF low with high 0, no inhibit -> next cycle high=1, low=0. Same-cycle RW to MCYCLEH=5 -> high=5, low increments normally. Set mcountinhibit=1 -> mcycle frozen from the following cycle.
- Drop rst_n during TRAP state -> outputs 0, FSM IDLE, no redirect pulse after release.
